pipe_result_collector: RTL and testbench
========================================

# pipe_result_collector

Tail end of the exponential-series pipeline. Captures each result leaving the last `register_group_pipe` stage (`y`, `x`, `ovf`, `valid`) into a small result FIFO and presents it to the downstream consumer over a valid/ready handshake. The pipeline itself cannot stall, so this block also runs a credit counter. The counter tells the front-end issuer when it may launch a new operand without risking a FIFO overrun.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries and initial credit count; power of two, at least 2.
- `PTR_W`, default 2: log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `init`  in  1  synchronous clear. Same effect as reset, applied on the clock edge.
- `in_valid`  in  1  last pipeline stage holds a finished result.
- `in_y`  in  32  series sum.
- `in_x`  in  8  original operand, returned as a tag.
- `in_ovf`  in  1  overflow flag raised during the series.
- `issue_fire`  in  1  issuer launched one operand into the pipeline this cycle.
- `can_issue`  out  1  at least one credit is available.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_y`  out  32  head result, saturated per the rule under Operation.
- `out_x`  out  8  head tag.
- `out_ovf`  out  1  head overflow flag.
- `err_overrun`  out  1  sticky error: a push arrived while the FIFO was full.
- `count`  out  PTR_W+1  current FIFO occupancy.

## Operation
- Push: `in_valid`=1 writes the entry {`ovf`, `x`, `y`} at the write pointer.
- Pop: `out_valid` & `out_ready` advances the read pointer.
- Pointers are `PTR_W`+1 bits wide; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- Push while full:
  - Same-cycle pop occurs: both the push and the pop are accepted.
  - No pop: the entry is dropped, `err_overrun` is set, and the pointers and `count` stay unchanged.
- Pop while empty is impossible, because `out_valid`=0 when the FIFO is empty.
- Credits: counter ranges 0..`DEPTH` and resets to `DEPTH`.
  - `issue_fire` alone: decrement.
  - Pop alone: increment.
  - Both in the same cycle: unchanged.
  - `issue_fire` at 0 credits: counter holds at 0 and `err_overrun` is set. This is an issuer protocol violation.
  - `can_issue` = (credits != 0), decoded combinationally from the counter.
- Saturation: `out_y` = `out_ovf` ? 32'hFFFF_FFFF : stored `y`. `out_x` and `out_ovf` pass through unmodified.
- `err_overrun` clears only on `rst` or `init`.
- `init` and `rst` clear the pointers, `count`, and `err_overrun`, and restore credits to `DEPTH`. FIFO storage is not cleared; it is don't-care.
- Reset values: `out_valid`=0, `can_issue`=1, `count`=0, `err_overrun`=0. `out_y`/`out_x`/`out_ovf` follow the head entry and are ignored while `out_valid`=0.

## Timing
- Entry pushed at edge k appears on the outputs with `out_valid`=1 after edge k, i.e. in cycle k+1. The FIFO is first-word-fall-through and the head is read combinationally from storage.
- A pop at edge k presents the next entry in cycle k+1. Back-to-back pops sustain 1 result per cycle.
- Credit returned by a pop at edge k: `can_issue` rises in cycle k+1.
- `rst` assertion takes effect immediately and asynchronously. Release is synchronous to `clk`; the first push is accepted on the first edge after release.
- `init` has priority over a push, pop, or `issue_fire` in the same cycle.
- Safe steady state: an issuer that obeys `can_issue` never causes an overrun for any pipeline depth.

## Structure
- Shared package `exp_pipe_pkg`:
  - `DATA_W`=32, `X_W`=8, `N_W`=4.
  - `RES_W` = `DATA_W`+`X_W`+1.
  - `SAT_VALUE` = 32'hFFFF_FFFF.
- Sub-module `result_fifo` (parameters `DEPTH`, `WIDTH`): storage, pointers, full/empty, `count`.
- Top level holds the credit counter, the saturation mux, and `err_overrun`.

## Test plan
- Reset then idle: `count`=0, `out_valid`=0, `can_issue`=1, credits=4.
- Four issues with `out_ready`=0, then four results with y=1..4: `can_issue`=0 after the 4th issue, `count`=4. Raising `out_ready` drains 1,2,3,4 in four consecutive cycles, and `can_issue` returns to 1 one cycle after the first pop.
- Push with `in_ovf`=1, y=32'h1234: `out_y`=32'hFFFF_FFFF, `out_ovf`=1, `out_x` equals the pushed tag.
- Full FIFO, push with a simultaneous pop: `count` stays 4, `err_overrun`=0, and the new entry is last in order.
- Full FIFO, push with no pop: `err_overrun`=1, `count`=4, and the dropped value is never output. `init` then clears all state and restores credits to 4.
- `rst` low mid-drain with 2 entries queued: `out_valid`=0 and credits=4 immediately, before the next clock edge.

Source files
------------

// File: rtl/exp_pipe_pkg.sv
// Shared widths and result bundle for the exponential-series pipeline.
// Imported by every stage that touches a finished result.
package exp_pipe_pkg;
   localparam int DATA_W = 32;
   localparam int X_W    = 8;
   localparam int N_W    = 4;
   localparam int RES_W  = DATA_W + X_W + 1;

   localparam logic [DATA_W-1:0] SAT_VALUE = 32'hFFFF_FFFF;

   typedef struct packed {
      logic              ovf;
      logic [X_W-1:0]    x;
      logic [DATA_W-1:0] y;
   } res_t;
endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO with wrap-bit pointers.
// A push into a full FIFO is taken only when a pop frees a slot the same edge.
module result_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 41,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wptr;
   logic [PTR_W:0]   rptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wptr == rptr);
   assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                  (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign count = wptr - rptr;
   assign rdata = mem[rptr[PTR_W-1:0]];

   // Storage carries no reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[PTR_W-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (init) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
      end
   end
endmodule

// File: rtl/pipe_result_collector.sv
// Pipeline tail: buffers finished results, saturates on overflow and
// meters issue credits so a non-stalling pipeline cannot overrun the FIFO.
module pipe_result_collector
   import exp_pipe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_y,
   input  logic [X_W-1:0]    in_x,
   input  logic              in_ovf,
   input  logic              issue_fire,
   output logic              can_issue,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_y,
   output logic [X_W-1:0]    out_x,
   output logic              out_ovf,
   output logic              err_overrun,
   output logic [PTR_W:0]    count
);
   localparam logic [PTR_W:0] CREDIT_MAX = (PTR_W + 1)'(DEPTH);

   res_t           wr_res;
   res_t           head;
   logic           full;
   logic           empty;
   logic           pop;
   logic [PTR_W:0] credits;

   assign wr_res = '{ovf: in_ovf, x: in_x, y: in_y};

   result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RES_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .init  (init),
      .push  (in_valid),
      .pop   (pop),
      .wdata (wr_res),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign can_issue = (credits != '0);
   assign out_ovf   = head.ovf;
   assign out_x     = head.x;
   assign out_y     = head.ovf ? SAT_VALUE : head.y;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits     <= CREDIT_MAX;
         err_overrun <= 1'b0;
      end else if (init) begin
         credits     <= CREDIT_MAX;
         err_overrun <= 1'b0;
      end else begin
         case ({issue_fire, pop})
            2'b10: if (credits != '0) credits <= credits - 1'b1;
            2'b01: if (credits != CREDIT_MAX) credits <= credits + 1'b1;
            default: ;
         endcase
         // Dropped push or an issue with no credit left are both overruns.
         if ((in_valid & full & ~pop) | (issue_fire & ~can_issue))
            err_overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector with a queue-based reference
// model checked every cycle plus literal spot checks.
module tb_pipe_result_collector;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        init;
   logic        in_valid;
   logic [31:0] in_y;
   logic [7:0]  in_x;
   logic        in_ovf;
   logic        issue_fire;
   logic        can_issue;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_y;
   logic [7:0]  out_x;
   logic        out_ovf;
   logic        err_overrun;
   logic [2:0]  count;

   int vectors = 0;
   int miscompares = 0;

   pipe_result_collector #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .init        (init),
      .in_valid    (in_valid),
      .in_y        (in_y),
      .in_x        (in_x),
      .in_ovf      (in_ovf),
      .issue_fire  (issue_fire),
      .can_issue   (can_issue),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_y       (out_y),
      .out_x       (out_x),
      .out_ovf     (out_ovf),
      .err_overrun (err_overrun),
      .count       (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] y;
      logic [7:0]  x;
      logic        ovf;
   } ent_t;

   ent_t m_q[$];
   int   m_credits = DEPTH;
   bit   m_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of results plus a credit integer.
   always @(posedge clk or negedge rst) begin
      if (!rst || init) begin
         m_q.delete();
         m_credits = DEPTH;
         m_err = 1'b0;
      end else begin
         bit   popped;
         ent_t e;
         popped = (m_q.size() > 0) && out_ready;
         if (issue_fire && m_credits == 0) m_err = 1'b1;
         if (issue_fire && !popped && m_credits > 0) m_credits--;
         if (!issue_fire && popped && m_credits < DEPTH) m_credits++;
         if (popped) void'(m_q.pop_front());
         if (in_valid) begin
            if (m_q.size() < DEPTH) begin
               e.y = in_y;
               e.x = in_x;
               e.ovf = in_ovf;
               m_q.push_back(e);
            end else begin
               m_err = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("m_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      check("m_count", 32'(count), 32'(m_q.size()));
      check("m_can_issue", 32'(can_issue), 32'(m_credits != 0));
      check("m_err_overrun", 32'(err_overrun), 32'(m_err));
      if (m_q.size() != 0) begin
         check("m_out_y", out_y, m_q[0].ovf ? 32'hFFFF_FFFF : m_q[0].y);
         check("m_out_x", 32'(out_x), 32'(m_q[0].x));
         check("m_out_ovf", 32'(out_ovf), 32'(m_q[0].ovf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] y, input logic [7:0] x,
                       input logic ovf);
      in_valid = 1'b1;
      in_y = y;
      in_x = x;
      in_ovf = ovf;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      init = 1'b0;
      in_valid = 1'b0;
      in_y = '0;
      in_x = '0;
      in_ovf = 1'b0;
      issue_fire = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick();
      check("rst_count", 32'(count), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_can_issue", 32'(can_issue), 1);
      check("rst_err", 32'(err_overrun), 0);

      // Exhaust credits, then fill, then drain in order.
      issue_fire = 1'b1;
      repeat (4) tick();
      issue_fire = 1'b0;
      check("credits_gone", 32'(can_issue), 0);
      for (int i = 1; i <= 4; i++) push(32'(i), 8'(16 + i), 1'b0);
      check("fill_count", 32'(count), 4);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_y", out_y, 32'(i));
         tick();
         if (i == 1) check("credit_back", 32'(can_issue), 1);
      end
      out_ready = 1'b0;
      check("drained", 32'(out_valid), 0);

      // Overflow saturates the sum but keeps the tag.
      issue_fire = 1'b1;
      tick();
      issue_fire = 1'b0;
      push(32'h1234, 8'h5A, 1'b1);
      check("sat_y", out_y, 32'hFFFF_FFFF);
      check("sat_ovf", 32'(out_ovf), 1);
      check("sat_x", 32'(out_x), 32'h5A);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Full FIFO with simultaneous push and pop.
      issue_fire = 1'b1;
      repeat (4) tick();
      issue_fire = 1'b0;
      for (int i = 0; i < 4; i++) push(32'(100 + i), 8'(i), 1'b0);
      out_ready = 1'b1;
      push(32'd200, 8'hC8, 1'b0);
      check("pp_count", 32'(count), 4);
      check("pp_err", 32'(err_overrun), 0);
      check("pp_head", out_y, 32'd101);
      repeat (3) tick();
      check("pp_last", out_y, 32'd200);
      tick();
      out_ready = 1'b0;

      // Full FIFO with push and no pop: dropped and flagged.
      for (int i = 0; i < 4; i++) push(32'(300 + i), 8'(i), 1'b0);
      push(32'hDEAD, 8'hEE, 1'b0);
      check("ovr_err", 32'(err_overrun), 1);
      check("ovr_count", 32'(count), 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("ovr_drain_y", out_y, 32'(300 + i));
         tick();
      end
      out_ready = 1'b0;
      check("ovr_empty", 32'(out_valid), 0);
      check("ovr_sticky", 32'(err_overrun), 1);

      // init clears everything and restores four credits.
      push(32'd7, 8'd7, 1'b0);
      issue_fire = 1'b1;
      repeat (2) tick();
      issue_fire = 1'b0;
      init = 1'b1;
      tick();
      init = 1'b0;
      check("init_count", 32'(count), 0);
      check("init_err", 32'(err_overrun), 0);
      check("init_valid", 32'(out_valid), 0);
      issue_fire = 1'b1;
      repeat (3) tick();
      check("init_credit3", 32'(can_issue), 1);
      tick();
      issue_fire = 1'b0;
      check("init_credit4", 32'(can_issue), 0);

      // Asynchronous reset mid-drain with two entries queued.
      for (int i = 0; i < 3; i++) push(32'(500 + i), 8'(i), 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("pre_rst_count", 32'(count), 2);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 0);
      check("arst_can_issue", 32'(can_issue), 1);
      check("arst_count", 32'(count), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      push(32'd42, 8'd1, 1'b0);
      check("post_rst_push", out_y, 32'd42);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
